// File: rtl/mos6502_lite.sv
// mos6502_lite: 8-bit 6502-subset CPU core with A/X/Y, N/Z flags, reset-vector fetch,
// immediate/absolute addressing, JMP and a defined halt on unsupported opcodes.
module mos6502_lite #(
  parameter logic [15:0] RESET_VECTOR    = 16'hFFFC,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  di,
  output logic [15:0] ab,
  output logic [7:0]  dout,
  output logic        we,
  output logic        sync,
  output logic        halted,
  output logic [1:0]  nz,
  output logic [2:0]  state_dbg
);

  // Bus protocol (no valid/ready): ab/dout/we are registered and change only at
  // the rising edge; di must reflect mem[ab] within the same cycle; a write
  // commits at the rising edge that ends a cycle in which we=1.

  typedef enum logic [2:0] {
    VEC_LO, VEC_HI, FETCH, EXEC, ADL, ADH, MEM, HALT
  } state_t;

  typedef enum logic [1:0] {
    CLS_SHORT, CLS_ABS, CLS_ILLEGAL
  } op_class_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [7:0]  a, a_nxt;
  logic [7:0]  x, x_nxt;
  logic [7:0]  y, y_nxt;
  logic        n, n_nxt;
  logic        z, z_nxt;
  logic [7:0]  opcode, opcode_nxt;
  logic [7:0]  adl, adl_nxt;
  logic [15:0] ab_nxt;
  logic [7:0]  dout_nxt;
  logic        we_nxt;
  logic        sync_nxt;
  logic        halted_nxt;

  logic [15:0] pc_inc;
  logic [15:0] abs_addr;
  logic [7:0]  res;
  logic        upd_flags;

  assign pc_inc    = pc + 16'd1;
  assign abs_addr  = {di, adl};
  assign nz        = {n, z};
  assign state_dbg = state;

  function automatic op_class_t classify(input logic [7:0] op);
    case (op)
      8'hA9, 8'hA2, 8'hA0, 8'hE8, 8'hC8, 8'hCA,
      8'h88, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hEA: classify = CLS_SHORT;
      8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C,
      8'h4C:                                    classify = CLS_ABS;
      default:                                  classify = CLS_ILLEGAL;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= VEC_LO;
      ab     <= RESET_VECTOR;
      pc     <= 16'h0000;
      a      <= 8'h00;
      x      <= 8'h00;
      y      <= 8'h00;
      n      <= 1'b0;
      z      <= 1'b0;
      opcode <= 8'h00;
      adl    <= 8'h00;
      dout   <= 8'h00;
      we     <= 1'b0;
      sync   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      ab     <= ab_nxt;
      pc     <= pc_nxt;
      a      <= a_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      n      <= n_nxt;
      z      <= z_nxt;
      opcode <= opcode_nxt;
      adl    <= adl_nxt;
      dout   <= dout_nxt;
      we     <= we_nxt;
      sync   <= sync_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    a_nxt      = a;
    x_nxt      = x;
    y_nxt      = y;
    n_nxt      = n;
    z_nxt      = z;
    opcode_nxt = opcode;
    adl_nxt    = adl;
    ab_nxt     = ab;
    dout_nxt   = dout;
    we_nxt     = 1'b0;
    sync_nxt   = 1'b0;
    halted_nxt = halted;
    res        = 8'h00;
    upd_flags  = 1'b0;

    case (state)
      VEC_LO: begin
        adl_nxt   = di;
        ab_nxt    = RESET_VECTOR + 16'd1;
        state_nxt = VEC_HI;
      end

      VEC_HI: begin
        pc_nxt    = abs_addr;
        ab_nxt    = abs_addr;
        sync_nxt  = 1'b1;
        state_nxt = FETCH;
      end

      FETCH: begin
        opcode_nxt = di;
        pc_nxt     = pc_inc;
        ab_nxt     = pc_inc;
        case (classify(di))
          CLS_SHORT: state_nxt = EXEC;
          CLS_ABS:   state_nxt = ADL;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_nxt  = HALT;
              halted_nxt = 1'b1;
            end else begin
              state_nxt  = EXEC;
            end
          end
        endcase
      end

      EXEC: begin
        // Implied ops leave pc alone; the cycle's bus read is a dummy read.
        ab_nxt    = pc;
        sync_nxt  = 1'b1;
        state_nxt = FETCH;
        case (opcode)
          8'hA9: begin a_nxt = di; res = di; upd_flags = 1'b1; pc_nxt = pc_inc; ab_nxt = pc_inc; end
          8'hA2: begin x_nxt = di; res = di; upd_flags = 1'b1; pc_nxt = pc_inc; ab_nxt = pc_inc; end
          8'hA0: begin y_nxt = di; res = di; upd_flags = 1'b1; pc_nxt = pc_inc; ab_nxt = pc_inc; end
          8'hE8: begin res = x + 8'd1; x_nxt = res; upd_flags = 1'b1; end
          8'hC8: begin res = y + 8'd1; y_nxt = res; upd_flags = 1'b1; end
          8'hCA: begin res = x - 8'd1; x_nxt = res; upd_flags = 1'b1; end
          8'h88: begin res = y - 8'd1; y_nxt = res; upd_flags = 1'b1; end
          8'hAA: begin res = a; x_nxt = res; upd_flags = 1'b1; end
          8'hA8: begin res = a; y_nxt = res; upd_flags = 1'b1; end
          8'h8A: begin res = x; a_nxt = res; upd_flags = 1'b1; end
          8'h98: begin res = y; a_nxt = res; upd_flags = 1'b1; end
          default: ;
        endcase
      end

      ADL: begin
        adl_nxt   = di;
        pc_nxt    = pc_inc;
        ab_nxt    = pc_inc;
        state_nxt = ADH;
      end

      ADH: begin
        if (opcode == 8'h4C) begin
          pc_nxt    = abs_addr;
          ab_nxt    = abs_addr;
          sync_nxt  = 1'b1;
          state_nxt = FETCH;
        end else begin
          pc_nxt    = pc_inc;
          ab_nxt    = abs_addr;
          state_nxt = MEM;
          case (opcode)
            8'h8D: begin we_nxt = 1'b1; dout_nxt = a; end
            8'h8E: begin we_nxt = 1'b1; dout_nxt = x; end
            8'h8C: begin we_nxt = 1'b1; dout_nxt = y; end
            default: ;
          endcase
        end
      end

      MEM: begin
        case (opcode)
          8'hAD: begin a_nxt = di; res = di; upd_flags = 1'b1; end
          8'hAE: begin x_nxt = di; res = di; upd_flags = 1'b1; end
          8'hAC: begin y_nxt = di; res = di; upd_flags = 1'b1; end
          default: ;
        endcase
        ab_nxt    = pc;
        sync_nxt  = 1'b1;
        state_nxt = FETCH;
      end

      HALT: begin
        // Everything holds; only reset leaves this state.
        state_nxt = HALT;
      end
    endcase

    if (upd_flags) begin
      n_nxt = res[7];
      z_nxt = (res == 8'h00);
    end
  end

endmodule

// File: tb/tb_mos6502_lite.sv
// Self-checking bench for mos6502_lite: 64 KiB memory model with async reads,
// a store scoreboard fed from an expected queue, and per-scenario tasks.
module tb_mos6502_lite;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  di;
  logic [15:0] ab;
  logic [7:0]  dout;
  logic        we;
  logic        sync;
  logic        halted;
  logic [1:0]  nz;
  logic [2:0]  state_dbg;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign di = mem[ab];

  mos6502_lite #(.RESET_VECTOR(16'hFFFC), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .di(di), .ab(ab), .dout(dout), .we(we),
    .sync(sync), .halted(halted), .nz(nz), .state_dbg(state_dbg)
  );

  // Store monitor: every write cycle must match the head of the expected queue.
  always @(negedge clk) begin : store_mon
    logic [23:0] want;
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL store_unexpected: got ab=%h do=%h, required no write", ab, dout);
      end else begin
        want = exp_q.pop_front();
        if ({ab, dout} !== want) begin
          errors++;
          $display("FAIL store_data: got ab=%h do=%h, required ab=%h do=%h",
                   ab, dout, want[23:8], want[7:0]);
        end
      end
      checks++;
      if (sync !== 1'b0) begin
        errors++;
        $display("FAIL sync_with_we: got sync=%b, required 0", sync);
      end
      mem[ab] = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h02;
  endtask

  task automatic put(input logic [15:0] addr, input logic [7:0] data);
    mem[addr] = data;
  endtask

  // Reset, release, and step through VEC_LO/VEC_HI into the first FETCH.
  task automatic start();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick_n(2);
  endtask

  task automatic test_reset();
    clear_mem();
    reset = 1'b1;
    tick();
    checks++; if (ab !== 16'hFFFC) begin errors++; $display("FAIL rst_ab: got %h required FFFC", ab); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", we); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL rst_sync: got %b required 0", sync); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b required 0", halted); end
    checks++; if (nz !== 2'b00) begin errors++; $display("FAIL rst_nz: got %b required 00", nz); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_do: got %h required 00", dout); end
    reset = 1'b0;
    checks++; if (ab !== 16'hFFFC) begin errors++; $display("FAIL vec_lo_ab: got %h required FFFC", ab); end
    tick();
    checks++; if (ab !== 16'hFFFD) begin errors++; $display("FAIL vec_hi_ab: got %h required FFFD", ab); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL vec_hi_sync: got %b required 0", sync); end
    tick();
    checks++; if (ab !== 16'h0200) begin errors++; $display("FAIL boot_fetch_ab: got %h required 0200", ab); end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL boot_fetch_sync: got %b required 1", sync); end
  endtask

  task automatic test_load_store();
    clear_mem();
    put(16'h0200, 8'hA9); put(16'h0201, 8'h5A);
    put(16'h0202, 8'h8D); put(16'h0203, 8'h34); put(16'h0204, 8'h12);
    exp_q.push_back({16'h1234, 8'h5A});
    start();
    tick_n(2);
    checks++; if (ab !== 16'h0202) begin errors++; $display("FAIL ls_fetch2_ab: got %h required 0202", ab); end
    checks++; if (nz !== 2'b00) begin errors++; $display("FAIL ls_nz: got %b required 00", nz); end
    tick_n(3);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL ls_we: got %b required 1", we); end
    checks++; if (ab !== 16'h1234) begin errors++; $display("FAIL ls_store_ab: got %h required 1234", ab); end
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL ls_store_do: got %h required 5A", dout); end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL ls_we_drop: got %b required 0", we); end
    checks++; if (ab !== 16'h0205) begin errors++; $display("FAIL ls_next_ab: got %h required 0205", ab); end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL ls_next_sync: got %b required 1", sync); end
    checks++; if (mem[16'h1234] !== 8'h5A) begin errors++; $display("FAIL ls_mem: got %h required 5A", mem[16'h1234]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ls_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_abs_load();
    logic [7:0] prog [18];
    prog = '{8'hAD, 8'h00, 8'h40, 8'h8D, 8'h04, 8'h40, 8'hAC, 8'h01, 8'h40,
             8'hAE, 8'h05, 8'h40, 8'h8C, 8'h06, 8'h40, 8'h8E, 8'h07, 8'h40};
    clear_mem();
    for (int i = 0; i < 18; i++) put(16'h0200 + 16'(i), prog[i]);
    put(16'h4000, 8'h80); put(16'h4001, 8'h00); put(16'h4005, 8'h7F);
    exp_q.push_back({16'h4004, 8'h80});
    exp_q.push_back({16'h4006, 8'h00});
    exp_q.push_back({16'h4007, 8'h7F});
    start();
    tick_n(4);
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL abs_lda_nz: got %b required 10", nz); end
    checks++; if (ab !== 16'h0203) begin errors++; $display("FAIL abs_lda_next_ab: got %h required 0203", ab); end
    tick_n(4);
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL abs_sta_keeps_nz: got %b required 10", nz); end
    tick_n(4);
    checks++; if (nz !== 2'b01) begin errors++; $display("FAIL abs_ldy_nz: got %b required 01", nz); end
    tick_n(4);
    checks++; if (nz !== 2'b00) begin errors++; $display("FAIL abs_ldx_nz: got %b required 00", nz); end
    tick_n(8);
    checks++; if (ab !== 16'h0212) begin errors++; $display("FAIL abs_end_ab: got %h required 0212", ab); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abs_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_flags_wrap();
    logic [7:0] prog [12];
    prog = '{8'hA2, 8'hFF, 8'hE8, 8'hA0, 8'h00, 8'h88,
             8'h8E, 8'h00, 8'h10, 8'h8C, 8'h01, 8'h10};
    clear_mem();
    for (int i = 0; i < 12; i++) put(16'h0200 + 16'(i), prog[i]);
    exp_q.push_back({16'h1000, 8'h00});
    exp_q.push_back({16'h1001, 8'hFF});
    start();
    tick_n(2);
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL fw_ldx_nz: got %b required 10", nz); end
    tick();
    checks++; if (ab !== 16'h0203) begin errors++; $display("FAIL fw_dummy_read_ab: got %h required 0203", ab); end
    tick();
    checks++; if (nz !== 2'b01) begin errors++; $display("FAIL fw_inx_nz: got %b required 01", nz); end
    checks++; if (ab !== 16'h0203) begin errors++; $display("FAIL fw_inx_next_ab: got %h required 0203", ab); end
    tick_n(2);
    checks++; if (nz !== 2'b01) begin errors++; $display("FAIL fw_ldy_nz: got %b required 01", nz); end
    tick_n(2);
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL fw_dey_nz: got %b required 10", nz); end
    tick_n(8);
    checks++; if (ab !== 16'h020C) begin errors++; $display("FAIL fw_end_ab: got %h required 020C", ab); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fw_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_transfer_jmp();
    logic [7:0] prog [15];
    clear_mem();
    put(16'h0200, 8'hA9); put(16'h0201, 8'h80); put(16'h0202, 8'hAA);
    put(16'h0203, 8'h4C); put(16'h0204, 8'h00); put(16'h0205, 8'h03);
    prog = '{8'h8E, 8'h00, 8'h11, 8'hCA, 8'h8A, 8'hC8, 8'h8D, 8'h01, 8'h11,
             8'h8C, 8'h02, 8'h11, 8'hEA, 8'hEA, 8'hEA};
    for (int i = 0; i < 15; i++) put(16'h0300 + 16'(i), prog[i]);
    exp_q.push_back({16'h1100, 8'h80});
    exp_q.push_back({16'h1101, 8'h7F});
    exp_q.push_back({16'h1102, 8'h01});
    start();
    tick_n(2);
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL tj_lda_nz: got %b required 10", nz); end
    tick_n(2);
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL tj_tax_nz: got %b required 10", nz); end
    checks++; if (ab !== 16'h0203) begin errors++; $display("FAIL tj_jmp_fetch_ab: got %h required 0203", ab); end
    tick();
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL tj_adl_sync: got %b required 0", sync); end
    tick();
    checks++; if (ab !== 16'h0205) begin errors++; $display("FAIL tj_adh_ab: got %h required 0205", ab); end
    tick();
    checks++; if (ab !== 16'h0300) begin errors++; $display("FAIL tj_target_ab: got %h required 0300", ab); end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL tj_target_sync: got %b required 1", sync); end
    tick_n(6);
    checks++; if (nz !== 2'b00) begin errors++; $display("FAIL tj_dex_nz: got %b required 00", nz); end
    tick_n(12);
    checks++; if (ab !== 16'h030C) begin errors++; $display("FAIL tj_end_ab: got %h required 030C", ab); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tj_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_halt();
    int         bad;
    logic [2:0] hcode;
    clear_mem();
    put(16'h0200, 8'h4C); put(16'h0201, 8'h00); put(16'h0202, 8'h03);
    put(16'h0300, 8'h02);
    start();
    tick_n(4);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_entry: got %b required 1", halted); end
    checks++; if (ab !== 16'h0301) begin errors++; $display("FAIL halt_ab: got %h required 0301", ab); end
    hcode = state_dbg;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (halted !== 1'b1 || ab !== 16'h0301 || we !== 1'b0 || sync !== 1'b0 ||
          dout !== 8'h00 || state_dbg !== hcode) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles required 0", bad); end
    reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_clears: got %b required 0", halted); end
    checks++; if (ab !== 16'hFFFC) begin errors++; $display("FAIL halt_reset_ab: got %h required FFFC", ab); end
    tick();
    reset = 1'b0;
    tick_n(2);
    checks++; if (ab !== 16'h0200 || sync !== 1'b1) begin
      errors++; $display("FAIL halt_reboot: got ab=%h sync=%b required ab=0200 sync=1", ab, sync);
    end
  endtask

  task automatic test_async_reset_store();
    logic [7:0] prog [9];
    clear_mem();
    prog = '{8'hA2, 8'h11, 8'hA0, 8'h22, 8'hA9, 8'h80, 8'h8D, 8'h34, 8'h12};
    for (int i = 0; i < 9; i++) put(16'h0200 + 16'(i), prog[i]);
    start();
    tick_n(9);
    checks++; if (we !== 1'b1 || ab !== 16'h1234) begin
      errors++; $display("FAIL ar_pre_we: got we=%b ab=%h required we=1 ab=1234", we, ab);
    end
    checks++; if (nz !== 2'b10) begin errors++; $display("FAIL ar_pre_nz: got %b required 10", nz); end
    reset = 1'b1;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL ar_we_async: got %b required 0", we); end
    checks++; if (ab !== 16'hFFFC) begin errors++; $display("FAIL ar_ab_async: got %h required FFFC", ab); end
    checks++; if (nz !== 2'b00) begin errors++; $display("FAIL ar_nz_async: got %b required 00", nz); end
    prog = '{8'h8D, 8'h00, 8'h50, 8'h8E, 8'h01, 8'h50, 8'h8C, 8'h02, 8'h50};
    for (int i = 0; i < 9; i++) put(16'h0600 + 16'(i), prog[i]);
    put(16'hFFFD, 8'h06);
    exp_q.push_back({16'h5000, 8'h00});
    exp_q.push_back({16'h5001, 8'h00});
    exp_q.push_back({16'h5002, 8'h00});
    tick();
    reset = 1'b0;
    tick_n(2);
    checks++; if (ab !== 16'h0600) begin errors++; $display("FAIL ar_reboot_ab: got %h required 0600", ab); end
    tick_n(12);
    checks++; if (ab !== 16'h0609) begin errors++; $display("FAIL ar_end_ab: got %h required 0609", ab); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ar_pending: got %0d required 0", exp_q.size()); end
    checks++; if (mem[16'h1234] !== 8'hEA) begin errors++; $display("FAIL ar_no_commit: got %h required EA", mem[16'h1234]); end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_abs_load();
    test_flags_wrap();
    test_transfer_jmp();
    test_halt();
    test_async_reset_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
